// File: rtl/aes_serial_loader.sv
// Serial-to-parallel loader for the AES cores: assembles LSB-first data and key
// bit streams into BLK_W-wide words and holds a completed block until it is consumed.
module aes_serial_loader #(
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             load_key,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] blk_out,
  output logic [BLK_W-1:0] key_out,
  output logic             blk_valid,
  output logic             key_loaded,
  output logic             overrun
);

  localparam int CNT_W = (BLK_W > 2) ? $clog2(BLK_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLK_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] dcnt_r;
  logic [CNT_W-1:0] kcnt_r;
  logic             data_bit_s;
  logic             key_bit_s;
  logic             handshake_s;
  logic             data_take_s;
  logic             key_take_s;
  logic             drop_s;
  logic             key_loaded_next_s;

  // Classify the incoming bit and decide next state, acceptance and drop.
  always_comb begin
    data_bit_s   = bit_valid & ~load_key;
    key_bit_s    = bit_valid & load_key;
    handshake_s  = blk_valid & blk_ready;
    data_take_s  = 1'b0;
    key_take_s   = 1'b0;
    drop_s       = 1'b0;
    state_next_s = state_r;
    case (state_r)
      COLLECT: begin
        data_take_s = data_bit_s;
        key_take_s  = key_bit_s;
        if (data_bit_s && (dcnt_r == CNT_MAX)) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = COLLECT;
        end
      end
      HOLD: begin
        // A data bit riding on the handshake edge starts the next block.
        if (handshake_s) begin
          state_next_s = COLLECT;
          data_take_s  = data_bit_s;
          drop_s       = key_bit_s;
        end else begin
          state_next_s = HOLD;
          drop_s       = bit_valid;
        end
      end
      default: begin
        state_next_s = COLLECT;
      end
    endcase

    if (key_take_s && (kcnt_r == CNT_MAX)) begin
      key_loaded_next_s = 1'b1;
    end else if (key_take_s && (kcnt_r == CNT_ZERO)) begin
      key_loaded_next_s = 1'b0;
    end else begin
      key_loaded_next_s = key_loaded;
    end
  end

  // Loader state, shift registers, counters and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= COLLECT;
      dcnt_r     <= CNT_ZERO;
      kcnt_r     <= CNT_ZERO;
      blk_out    <= {BLK_W{1'b0}};
      key_out    <= {BLK_W{1'b0}};
      blk_valid  <= 1'b0;
      key_loaded <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      key_loaded <= key_loaded_next_s;
      blk_valid  <= (state_next_s == HOLD) && key_loaded_next_s;

      if (data_take_s) begin
        blk_out <= {bit_in, blk_out[BLK_W-1:1]};
        dcnt_r  <= (dcnt_r == CNT_MAX) ? CNT_ZERO : (dcnt_r + CNT_ONE);
      end else begin
        blk_out <= blk_out;
        dcnt_r  <= dcnt_r;
      end

      // Dropping load_key mid-load abandons the partial key.
      if (key_take_s) begin
        key_out <= {bit_in, key_out[BLK_W-1:1]};
        kcnt_r  <= (kcnt_r == CNT_MAX) ? CNT_ZERO : (kcnt_r + CNT_ONE);
      end else if (!load_key) begin
        key_out <= key_out;
        kcnt_r  <= CNT_ZERO;
      end else begin
        key_out <= key_out;
        kcnt_r  <= kcnt_r;
      end

      if (drop_s) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: doc/aes_serial_loader.md
AES_SERIAL_LOADER -- requirements
Module: aes_serial_loader

Interface
REQ-001 Parameter: BLK_W, default 128, width of the data block and of the key in bits.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: bit_in  input  1  serial data or key bit.
REQ-005 Port: bit_valid  input  1  bit_in is sampled on this clk edge.
REQ-006 Port: load_key  input  1  1 = the sampled bit goes to the key register; 0 = it goes to the block register.
REQ-007 Port: blk_ready  input  1  the downstream aes_encrypt/aes_decrypt consumer accepts blk_out.
REQ-008 Port: blk_out  output  BLK_W  assembled data block, in the column-major byte order used by the cipher cores.
REQ-009 Port: key_out  output  BLK_W  assembled key.
REQ-010 Port: blk_valid  output  1  blk_out and key_out are complete and stable.
REQ-011 Port: key_loaded  output  1  a full key has been received.
REQ-012 Port: overrun  output  1  sticky flag: a bit was dropped.

Function
REQ-013 Bit order is LSB-first: each accepted bit shifts in as reg <= {bit_in, reg[BLK_W-1:1]}; after BLK_W bits the first received bit is at bit 0, i.e. byte 0 occupies bits 7:0.
REQ-014 The block path state machine has two states: COLLECT and HOLD. In COLLECT, a 7-bit data counter dcnt counts accepted data bits.
REQ-015 A data bit is accepted in COLLECT when bit_valid=1 and load_key=0: the block shift register shifts and dcnt increments.
REQ-016 When the accepted data bit is bit BLK_W (dcnt=127 before the edge):
  - the state moves to HOLD;
  - dcnt wraps to 0;
  - the completed block is visible on blk_out on that same edge (latency 0 cycles after the last bit edge).
REQ-017 blk_valid = (state==HOLD) AND key_loaded, as a registered-state decode. In HOLD, blk_out and key_out shall not change.
REQ-018 Handshake: when blk_valid=1 and blk_ready=1 on an edge, the state returns to COLLECT. blk_ready has no effect while blk_valid=0.
REQ-019 In HOLD, a data bit (bit_valid=1, load_key=0) arriving without a completing handshake on the same edge is dropped and sets overrun.
REQ-020 A data bit arriving on the same edge as a completing handshake is accepted as the first bit of the next block: the state goes to COLLECT with dcnt=1.
REQ-021 Key path: a 7-bit counter kcnt counts key bits.
  - A key bit is accepted when bit_valid=1, load_key=1 and state==COLLECT.
  - On the first key bit (kcnt=0), key_loaded clears.
  - On bit BLK_W, key_loaded sets and kcnt wraps to 0.
REQ-022 A key bit arriving while state==HOLD is dropped and sets overrun; key_out and key_loaded are unchanged.
REQ-023 If load_key falls while 0<kcnt<BLK_W, kcnt clears to 0 and key_loaded stays 0; the next key load restarts from bit 0.
REQ-024 Block and key shifting are independent: an in-progress key load does not disturb dcnt or the block register, and vice versa.
REQ-025 overrun clears only on rst.
REQ-026 bit_in is ignored whenever bit_valid=0.

Reset
REQ-027 While rst=1, with no clock required:
  - state=COLLECT, dcnt=0, kcnt=0;
  - blk_out=0, key_out=0;
  - blk_valid=0, key_loaded=0, overrun=0.
REQ-028 A reset asserted mid-block or mid-key discards all partial bits. The first accepted bit after rst falls is bit 0.

Verification
REQ-029 Load 128 key bits of 0, then 128 data bits of pattern 0x00112233445566778899aabbccddeeff LSB-first, with blk_ready=0 -> key_loaded=1; blk_valid=1 on the edge of the 128th data bit; blk_out equals the pattern.
REQ-030 Send 128 data bits with no key loaded -> state=HOLD, blk_valid=0. Then send one key bit -> overrun=1, key_loaded stays 0.
REQ-031 Hold blk_valid=1 for 10 cycles with blk_ready=0 while driving data bits -> blk_out is constant and overrun=1. Then pulse blk_ready for 1 cycle -> blk_valid=0 the next cycle.
REQ-032 Assert blk_ready and bit_valid (data) on the same edge -> handshake completes, dcnt=1, the bit lands in the new block, overrun stays 0.
REQ-033 Load 64 key bits, drop load_key for one cycle, then load 128 key bits of all 1s -> key_out=all 1s, key_loaded=1.
REQ-034 Assert rst after 70 data bits -> all outputs 0. Then 128 fresh bits -> blk_out holds only the new bits.
